fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoders (`i_instr`, `r_instr`, `s_instr`, `sb_instr`, `u_instr`, `uj_instr`). It reads 64-byte cache lines from the system bus, buffers the 16 instructions of a line, and presents them one per cycle to decode with a valid/ready handshake. It supports redirects (jump/branch target) from later stages.

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decoders. It reads one 64-byte line
// from the system bus as eight 64-bit beats, buffers the sixteen 32-bit
// instructions, and presents them one per cycle with a valid/ready
// handshake. A redirect from a later stage flushes and refetches from the
// new PC at any time.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   bus_reqcyc/req    line read request and its 64-byte aligned address
//   bus_reqack        bus accepted the request this cycle
//   bus_respcyc/resp  response beat valid and its data
//   bus_respack       beat accepted this cycle (combinational in RESP)
//   redirect_valid/pc flush and refetch from redirect_pc (bits [1:0] dropped)
//   instr, instr_pc   instruction to decode and its address
//   instr_valid/ready decode handshake
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  // system bus
  output logic        bus_reqcyc,
  output logic [63:0] bus_req,
  input  logic        bus_reqack,
  input  logic        bus_respcyc,
  input  logic [63:0] bus_resp,
  output logic        bus_respack,
  // redirect from later stages
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  // decode side
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_RESP  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [63:0] pc_q,       pc_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic        squash_q,   squash_d;
  logic [31:0] line_buf_q [16];
  logic [31:0] line_buf_d [16];

  // The two low redirect bits are forced to zero and otherwise ignored.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // -------------------------------------------------------------------------
  // Outputs. Every output is gated with reset so that the whole interface
  // reads zero while reset is held, including the cycle it is first raised.
  // -------------------------------------------------------------------------
  always_comb begin
    bus_reqcyc  = !reset && (state_q == ST_REQ);
    bus_req     = bus_reqcyc ? {pc_q[63:6], 6'b0} : 64'd0;
    bus_respack = !reset && (state_q == ST_RESP) && bus_respcyc;
    instr_valid = !reset && (state_q == ST_DRAIN);
    instr       = instr_valid ? line_buf_q[pc_q[5:2]] : 32'd0;
    instr_pc    = instr_valid ? pc_q : 64'd0;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    beat_cnt_d = beat_cnt_q;
    squash_d   = squash_q;
    line_buf_d = line_buf_q;

    case (state_q)
      ST_REQ: begin
        if (bus_reqack) begin
          // A request accepted in the same cycle as a redirect is still
          // owed eight beats; they are collected and thrown away.
          state_d    = ST_RESP;
          beat_cnt_d = 3'd0;
          squash_d   = redirect_valid;
        end
      end

      ST_RESP: begin
        squash_d = squash_q | redirect_valid;
        if (bus_respcyc) begin
          // Little-endian: low half of the beat is the lower instruction.
          line_buf_d[{beat_cnt_q, 1'b0}] = bus_resp[31:0];
          line_buf_d[{beat_cnt_q, 1'b1}] = bus_resp[63:32];
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (beat_cnt_q == 3'd7) begin
            // Last beat: a squashed line is dropped and the (already
            // redirected) PC is requested instead.
            state_d  = (squash_q || redirect_valid) ? ST_REQ : ST_DRAIN;
            squash_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          // A same-cycle handshake is ignored: nothing is consumed.
          state_d = ST_REQ;
        end else if (instr_ready) begin
          pc_d = pc_q + 64'd4;
          if (pc_q[5:2] == 4'hF) begin
            state_d = ST_REQ;
          end
        end
      end

      default: state_d = ST_REQ;
    endcase

    // Redirect owns the PC in every state.
    if (redirect_valid) begin
      pc_d = {redirect_pc[63:2], 2'b00};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      beat_cnt_q <= 3'd0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_cnt_q <= beat_cnt_d;
      squash_q   <= squash_d;
    end
  end

  // NOTE: the line buffer is intentionally not reset; it is always fully
  // rewritten by eight beats before DRAIN can read it, so a reset would only
  // add fan-out on sixteen 32-bit registers.
  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A bus model answers line requests with data that is
// a pure function of the byte address. The reference model is the
// architectural instruction stream: a PC that advances by 4 per consumed
// instruction and jumps on redirect; its upcoming (pc, word) pairs sit in a
// queue which a monitor pops and compares on every decode handshake.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic        bus_reqack = 1'b0;
  logic        bus_respcyc = 1'b0;
  logic [63:0] bus_resp = 64'd0;
  logic        bus_respack;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_respack    (bus_respack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ memory image
  bit simple_mode = 1'b1;  // word = instruction index within its line

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (simple_mode) return {28'd0, a[5:2]};
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  // --------------------------------------------------------------- bus model
  int ack_delay = 0;    // cycles of bus_reqcyc before ack (fixed mode)
  bit ack_rand  = 1'b0;
  int ack_cur   = 0;
  int ack_cnt   = 0;
  int max_lat   = 0;    // idle cycles between ack and first beat
  int gap_pct   = 0;    // chance of an idle cycle between beats
  bit          b_busy = 1'b0;
  int          b_beat = 0;
  int          b_lat  = 0;
  logic [63:0] b_line = 64'd0;

  initial begin
    forever begin
      @(posedge clk); #1;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp    = 64'd0;
      if (bus_reqcyc && !b_busy) begin
        if (ack_cnt >= (ack_rand ? ack_cur : ack_delay)) bus_reqack = 1'b1;
        ack_cnt++;
      end
      if (b_busy) begin
        if (b_lat > 0) b_lat--;
        else if (gap_pct == 0 || $urandom_range(99) >= gap_pct) begin
          bus_respcyc = 1'b1;
          bus_resp    = {word_at(b_line + 64'(b_beat * 8 + 4)),
                         word_at(b_line + 64'(b_beat * 8))};
        end
      end
      @(negedge clk);
      if (reset) begin
        b_busy  = 1'b0;
        ack_cnt = 0;
      end else if (bus_reqcyc && bus_reqack) begin
        b_busy  = 1'b1;
        b_line  = bus_req;
        b_beat  = 0;
        b_lat   = (max_lat > 0) ? $urandom_range(max_lat) : 0;
        ack_cnt = 0;
        ack_cur = $urandom_range(4);
      end else if (b_busy && bus_respcyc && bus_respack) begin
        b_beat++;
        if (b_beat == 8) b_busy = 1'b0;
      end
    end
  end

  // --------------------------------------------- reference model + monitor
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_next = RST_PC;

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_next, word: word_at(model_next)});
      model_next += 64'd4;
    end
  endtask

  int          cyc = 0;
  int          hs_count = 0;
  int          first_hs_cyc = -1;
  int          last_hs_cyc = 0;
  int          beat8_cyc = -1;
  logic [63:0] last_hs_pc = 64'd0;

  initial begin
    bit          m_busy = 1'b0;
    int          m_beats = 0;
    bit          prev_stall = 1'b0;
    bit          prev_req_wait = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_instr = 32'd0;
    logic [63:0] prev_pc = 64'd0;
    logic [63:0] prev_req = 64'd0;
    logic [63:0] prev_redir_line = 64'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        model_next = RST_PC;
        refill();
        m_busy = 1'b0; prev_stall = 1'b0; prev_req_wait = 1'b0; prev_redir = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", instr_valid, 1'b1);
        check("stall_instr", instr, prev_instr);
        check("stall_pc", instr_pc, prev_pc);
      end
      if (prev_req_wait) begin
        check("req_hold_cyc", bus_reqcyc, 1'b1);
        check("req_hold_addr", bus_req, prev_req);
      end
      if (prev_redir) begin
        check("redir_lat_cyc", bus_reqcyc, 1'b1);
        check("redir_lat_addr", bus_req, prev_redir_line);
      end
      if (m_busy) begin
        check("resp_no_valid", instr_valid, 1'b0);
        check("resp_no_reqcyc", bus_reqcyc, 1'b0);
        check("respack", bus_respack, bus_respcyc);
      end else begin
        check("req_or_drain", bus_reqcyc ^ instr_valid, 1'b1);
        check("respack_idle", bus_respack, 1'b0);
      end
      if (bus_reqcyc && bus_reqack)
        check("req_addr", bus_req, {exp_q[0].pc[63:6], 6'b0});
      if (instr_valid && instr_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.word);
        hs_count++;
        if (hs_count == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        last_hs_pc  = instr_pc;
        refill();
      end
      prev_stall      = instr_valid && !instr_ready && !redirect_valid;
      prev_instr      = instr;
      prev_pc         = instr_pc;
      prev_req_wait   = bus_reqcyc && !bus_reqack && !redirect_valid;
      prev_req        = bus_req;
      prev_redir      = redirect_valid && !m_busy && !(bus_reqcyc && bus_reqack);
      prev_redir_line = {redirect_pc[63:6], 6'b0};
      if (redirect_valid) begin
        exp_q.delete();
        model_next = {redirect_pc[63:2], 2'b00};
        refill();
      end
      if (bus_reqcyc && bus_reqack) begin
        m_busy  = 1'b1;
        m_beats = 0;
      end else if (m_busy && bus_respcyc && bus_respack) begin
        m_beats++;
        if (m_beats == 8) begin
          m_busy    = 1'b0;
          beat8_cyc = cyc;
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_count < target && n < 2000) begin tick(); n++; end
    check({name, "_progress"}, hs_count >= target, 1'b1);
  endtask

  task automatic wait_valid_idx(input logic [3:0] idx, input string name);
    int n = 0;
    tick();
    while (!(instr_valid && instr_pc[5:2] == idx) && n < 2000) begin tick(); n++; end
    check({name, "_reached"}, instr_valid && instr_pc[5:2] == idx, 1'b1);
  endtask

  task automatic wait_beats(input int k, input string name);
    int n = 0;
    while (!(b_busy && b_beat == k) && n < 2000) begin tick(); n++; end
    check({name, "_reached"}, b_busy && b_beat == k, 1'b1);
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
  endtask

  task automatic finish_run();
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int base;
    int n;
    repeat (3) tick();
    check("rst_reqcyc", bus_reqcyc, 1'b0);
    check("rst_req", bus_req, 64'd0);
    check("rst_respack", bus_respack, 1'b0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    check("rst_valid", instr_valid, 1'b0);

    // Line at reset PC: immediate ack, back-to-back beats, 16 instrs.
    reset = 1'b0; #1;
    check("first_reqcyc", bus_reqcyc, 1'b1);
    check("first_req", bus_req, 64'h1000);
    wait_hs(16, "line0");
    check("line0_rate", last_hs_cyc - first_hs_cyc, 15);
    check("valid_after_beat8", first_hs_cyc, beat8_cyc + 1);
    check("seq_reqcyc", bus_reqcyc, 1'b1);
    check("seq_req", bus_req, 64'h1040);

    // Misaligned redirect during DRAIN.
    n = 0;
    while (!instr_valid && n < 200) begin tick(); n++; end
    do_redirect(64'h2036);
    check("redir_reqcyc", bus_reqcyc, 1'b1);
    check("redir_req", bus_req, 64'h2000);
    base = hs_count;
    wait_hs(base + 1, "redir_first");
    check("redir_first_pc", last_hs_pc, 64'h2034);
    wait_hs(base + 3, "redir_three");
    check("redir_next_reqcyc", bus_reqcyc, 1'b1);
    check("redir_next_req", bus_req, 64'h2040);

    // Decode stalls for 4 cycles at index 5.
    wait_valid_idx(4'd5, "stall_idx5");
    instr_ready = 1'b0;
    repeat (4) tick();
    check("stalled_pc", instr_pc, 64'h2054);
    check("stalled_instr", instr, 32'd5);
    instr_ready = 1'b1;
    base = hs_count;
    wait_hs(base + 1, "resume5");
    check("resume_pc5", last_hs_pc, 64'h2054);
    wait_hs(base + 2, "resume6");
    check("resume_pc6", last_hs_pc, 64'h2058);

    // Redirect coinciding with the handshake at index 15.
    wait_valid_idx(4'd15, "idx15");
    base = hs_count;
    do_redirect(64'h5008);
    check("idx15_not_consumed", hs_count, base);
    check("idx15_reqcyc", bus_reqcyc, 1'b1);
    check("idx15_req", bus_req, 64'h5000);

    // Reset in the middle of a response; hashed data from here on.
    wait_beats(2, "rst_mid");
    reset = 1'b1;
    simple_mode = 1'b0;
    tick();
    check("rstmid_reqcyc", bus_reqcyc, 1'b0);
    check("rstmid_req", bus_req, 64'd0);
    check("rstmid_respack", bus_respack, 1'b0);
    check("rstmid_instr", instr, 32'd0);
    check("rstmid_instr_pc", instr_pc, 64'd0);
    check("rstmid_valid", instr_valid, 1'b0);
    tick();
    reset = 1'b0; #1;
    check("rstmid_rel_reqcyc", bus_reqcyc, 1'b1);
    check("rstmid_rel_req", bus_req, 64'h1000);

    // Redirect after the third beat: the line completes and is dropped.
    wait_beats(3, "squash");
    do_redirect(64'h3000);
    n = 0;
    while (b_busy && n < 200) begin tick(); n++; end
    check("squash_all_beats", b_beat, 8);
    check("squash_reqcyc", bus_reqcyc, 1'b1);
    check("squash_req", bus_req, 64'h3000);
    base = hs_count;
    wait_hs(base + 1, "squash_first");
    check("squash_first_pc", last_hs_pc, 64'h3000);

    // Slow ack and gapped beats.
    ack_delay = 10;
    gap_pct   = 50;
    max_lat   = 3;
    base = hs_count;
    wait_hs(base + 24, "slow_bus");

    // Randomised traffic, starting with a fetch that wraps past 2^64.
    ack_rand = 1'b1;
    gap_pct  = 30;
    do_redirect(64'hFFFF_FFFF_FFFF_FFFA);
    base = hs_count;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom(), $urandom()};
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    check("random_progress", hs_count > base + 100, 1'b1);
    finish_run();
  end

  initial begin
    repeat (60000) @(posedge clk);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL watchdog: got %0d cycles want fewer", cyc);
      finish_run();
    end
  end

endmodule
